// File: rtl/dmem_if.sv
// Data-memory arbitration bus: CPU port, video port and single-port RAM side.
interface dmem_if #(
    parameter int unsigned AW = 32
) ();
    localparam int unsigned DW = 32;

    // CPU data port
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_stall;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;

    // Video fetch port
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_gnt;
    logic          vid_rvalid;
    logic [DW-1:0] vid_rdata;

    // RAM port
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_stall, cpu_rvalid, cpu_rdata,
        input  vid_req, vid_addr,
        output vid_gnt, vid_rvalid, vid_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // Requester / RAM side
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_stall, cpu_rvalid, cpu_rdata,
        output vid_req, vid_addr,
        input  vid_gnt, vid_rvalid, vid_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: CPU-first with a video starvation override.
module dmem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 3,
    parameter int unsigned AW           = 32
) (
    input  logic  clk,
    input  logic  reset,
    dmem_if.slave bus
);
    localparam int unsigned CW = 4;
    localparam int unsigned DW = 32;

    localparam logic [0:0] PRI_CPU = 1'b0;
    localparam logic [0:0] PRI_VID = 1'b1;

    localparam logic [CW-1:0] STARVE_MAX = '1;
    localparam logic [CW-1:0] LIMIT      = CW'(STARVE_LIMIT);

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] starve_q, starve_d;
    logic          cpu_win;
    logic          vid_win;
    logic          rd_cpu_q;
    logic          rd_vid_q;
    logic [AW-1:0] addr_c;
    logic [DW-1:0] wdata_c;

    // State, starve counter and pending-read tags
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= PRI_CPU;
            starve_q <= '0;
            rd_cpu_q <= 1'b0;
            rd_vid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            rd_cpu_q <= cpu_win & ~bus.cpu_we;
            rd_vid_q <= vid_win;
        end
    end

    // Grant decision, starve counter update and priority transitions
    always_comb begin
        cpu_win  = 1'b0;
        vid_win  = 1'b0;
        state_d  = state_q;
        starve_d = '0;
        if (!reset) begin
            if (state_q == PRI_VID) begin
                vid_win = bus.vid_req;
                cpu_win = bus.cpu_req & ~bus.vid_req;
            end else begin
                cpu_win = bus.cpu_req;
                vid_win = bus.vid_req & ~bus.cpu_req;
            end
        end
        if (bus.vid_req && !vid_win) begin
            starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + CW'(1);
        end
        case (state_q)
            PRI_CPU: if (starve_d == LIMIT) state_d = PRI_VID;
            PRI_VID: if (vid_win || !bus.vid_req) state_d = PRI_CPU;
            default: state_d = PRI_CPU;
        endcase
    end

    // RAM request mux; idle bus is driven to zero
    always_comb begin
        addr_c  = '0;
        wdata_c = '0;
        if (cpu_win) begin
            addr_c  = bus.cpu_addr;
            wdata_c = bus.cpu_wdata;
        end else if (vid_win) begin
            addr_c  = bus.vid_addr;
        end
    end

    assign bus.mem_en    = cpu_win | vid_win;
    assign bus.mem_we    = cpu_win & bus.cpu_we;
    assign bus.mem_addr  = addr_c;
    assign bus.mem_wdata = wdata_c;

    assign bus.cpu_stall = bus.cpu_req & ~cpu_win & ~reset;
    assign bus.vid_gnt   = vid_win;

    // Read returns are masked during reset so a tag set just before reset never shows
    assign bus.cpu_rvalid = rd_cpu_q & ~reset;
    assign bus.vid_rvalid = rd_vid_q & ~reset;
    assign bus.cpu_rdata  = bus.cpu_rvalid ? bus.mem_rdata : '0;
    assign bus.vid_rdata  = bus.vid_rvalid ? bus.mem_rdata : '0;
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL provide parameter STARVE_LIMIT, default 3, the number of consecutive denied video-request cycles that forces video priority (legal range 1-15).
REQ-002 SHALL provide parameter AW, default 32, the address width of all address ports.
REQ-003 SHALL have a single clock domain; reset is synchronous and active-high.
REQ-004 SHALL have the following ports, one per line (name, direction, width, meaning):
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous active-high reset.
- cpu_req  in  1  CPU data access this cycle (load or store).
- cpu_we  in  1  CPU store when 1, load when 0.
- cpu_addr  in  AW  CPU byte address (aluout).
- cpu_wdata  in  32  CPU store data (writedata).
- cpu_stall  out  1  CPU access not granted this cycle; the CPU holds its PC and request.
- cpu_rvalid  out  1  CPU load data valid.
- cpu_rdata  out  32  CPU load data (readdata).
- vid_req  in  1  video fetch request; held until granted.
- vid_addr  in  AW  video fetch address.
- vid_gnt  out  1  video request accepted this cycle.
- vid_rvalid  out  1  video read data valid.
- vid_rdata  out  32  video read data.
- mem_en  out  1  RAM access enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  32  RAM write data.
- mem_rdata  in  32  RAM read data, valid one cycle after mem_en with mem_we=0.

Function
REQ-005 SHALL implement a two-state FSM: PRI_CPU (reset state) and PRI_VID.
REQ-006 In PRI_CPU, SHALL grant the CPU when cpu_req=1; otherwise it SHALL grant video when vid_req=1.
REQ-007 In PRI_VID, SHALL grant video when vid_req=1; otherwise it SHALL grant the CPU when cpu_req=1.
REQ-008 SHALL grant at most one requester per cycle.
REQ-009 Grant is combinational in the request cycle:
- mem_en=1.
- mem_addr/mem_we/mem_wdata taken from the granted port.
- mem_we=0 and mem_wdata=0 for a video grant.
REQ-010 With no grant, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-011 cpu_stall SHALL equal cpu_req AND NOT cpu_granted in the same cycle.
REQ-012 vid_gnt SHALL equal the video grant in the same cycle.
REQ-013 A granted read SHALL produce exactly one rvalid pulse on the owning port one cycle later, with rdata=mem_rdata in that cycle. Latency is 1.
REQ-014 A granted store SHALL produce no rvalid.
REQ-015 cpu_rdata and vid_rdata SHALL read 0 when their rvalid is 0.
REQ-016 SHALL keep a 4-bit starve counter:
- Increments each cycle vid_req=1 and video is not granted.
- Saturates at 15.
- Clears on any video grant or when vid_req=0.
REQ-017 PRI_CPU -> PRI_VID at the clock edge where the post-update starve counter equals STARVE_LIMIT.
REQ-018 PRI_VID -> PRI_CPU at the edge after a video grant, or at any edge with vid_req=0.
REQ-019 Simultaneous cpu_req and vid_req in PRI_VID SHALL grant video and stall the CPU for exactly that cycle.
REQ-020 Back-to-back grants to alternating requesters SHALL each produce correctly routed rvalid pulses, with no loss or duplication.

Reset
REQ-021 While reset=1, all outputs SHALL be 0, regardless of requests, and no RAM access SHALL be issued.
REQ-022 At the first rising edge with reset=1:
- The FSM SHALL go to PRI_CPU.
- The starve counter SHALL go to 0.
- The pending-read tag SHALL be cleared.
REQ-023 A read granted in the cycle before reset asserts SHALL NOT produce an rvalid after reset.

Verification
REQ-024 CPU load alone: cpu_req=1, cpu_we=0, cpu_addr=0x40, RAM[0x40]=0xDEADBEEF -> mem_en=1, cpu_stall=0; next cycle cpu_rvalid=1, cpu_rdata=0xDEADBEEF.
REQ-025 CPU store: cpu_we=1, cpu_addr=0x80, cpu_wdata=0x12345678 -> mem_we=1, mem_wdata=0x12345678; cpu_rvalid stays 0; a later load from 0x80 returns 0x12345678.
REQ-026 Starvation: cpu_req=1 and vid_req=1 held continuously, STARVE_LIMIT=3 -> CPU granted cycles 0-2; video granted cycle 3 with cpu_stall=1; CPU granted again cycle 4; pattern repeats every 4 cycles.
REQ-027 Video only: vid_req=1, vid_addr=0x1000 -> vid_gnt=1 the same cycle; vid_rvalid=1 next cycle with RAM[0x1000] data.
REQ-028 Reset mid-read: video read granted at cycle N, reset=1 at cycle N+1 -> vid_rvalid=0 at N+1 and after; all outputs 0; FSM in PRI_CPU after release.
REQ-029 Interleave: CPU read at 0x10 in cycle N, video read at 0x20 in cycle N+1 -> cpu_rvalid only at N+1 and vid_rvalid only at N+2, each with its own address's data.
